seg_digit_scheduler: RTL and testbench

- Time-shares one registered binary-to-7-segment encoder between the two display digits of the Go Board.
- Accepts an 8-bit value with a load strobe.
- Sequences the low nibble and then the high nibble through the shared encoder, capturing each result into a per-digit active-low segment register.
- Sits between the counter/control logic and the board segment pins; replaces one encoder instance per digit.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_digit_scheduler_if.sv | 22 ++
 rtl/seg_digit_scheduler.sv | 145 ++++++++++++++
 tb/tb_seg_digit_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the time-shared 7-segment digit scheduler.
package seg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRV_LO,
        WAIT_LO,
        DRV_HI,
        WAIT_HI
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam int DEFAULT_ENC_LATENCY    = 1;
    localparam int DEFAULT_REFRESH_CYCLES = 250000;

endpackage

// File: rtl/seg_digit_scheduler_if.sv
// Value/load, shared-encoder and segment-pin signals of the digit scheduler.
interface seg_digit_scheduler_if;

    logic [7:0] i_Value;
    logic       i_Load;
    logic       o_Busy;
    logic [3:0] o_Enc_Num;
    logic [6:0] i_Enc_Seg;
    logic [6:0] o_Segment1;
    logic [6:0] o_Segment2;

    modport slave (
        input  i_Value, i_Load, i_Enc_Seg,
        output o_Busy, o_Enc_Num, o_Segment1, o_Segment2
    );

    modport master (
        output i_Value, i_Load, i_Enc_Seg,
        input  o_Busy, o_Enc_Num, o_Segment1, o_Segment2
    );

endinterface

// File: rtl/seg_digit_scheduler.sv
// Sequences both nibbles of a held value through one shared 7-segment encoder.
// Optional: define SEG_LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module seg_digit_scheduler
    import seg_pkg::*;
#(
    parameter int ENC_LATENCY    = DEFAULT_ENC_LATENCY,
    parameter int REFRESH_CYCLES = DEFAULT_REFRESH_CYCLES
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    seg_digit_scheduler_if.slave  bus
);

    localparam int         RW           = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit         REFRESH_EN   = (REFRESH_CYCLES > 0);
    localparam logic [RW-1:0] REFRESH_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    // The low nibble waits one extra cycle so its capture lands ENC_LATENCY+1 after the drive edge.
    localparam logic [2:0] LAT_LO       = 3'(ENC_LATENCY);
    localparam logic [2:0] LAT_HI       = 3'(ENC_LATENCY - 1);

    state_e        state_q,      state_d;
    logic [7:0]    value_q,      value_d;
    logic [7:0]    pend_value_q, pend_value_d;
    logic          pend_valid_q, pend_valid_d;
    logic [3:0]    enc_num_q,    enc_num_d;
    logic [2:0]    wait_q,       wait_d;
    logic [RW-1:0] refresh_q,    refresh_d;
    logic [6:0]    seg1_q,       seg1_d;
    logic [6:0]    seg2_q,       seg2_d;
    logic          busy_q,       busy_d;
    logic          start;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        value_d      = value_q;
        pend_value_d = pend_value_q;
        pend_valid_d = pend_valid_q;
        enc_num_d    = enc_num_q;
        wait_d       = wait_q;
        refresh_d    = refresh_q;
        seg1_d       = seg1_q;
        seg2_d       = seg2_q;
        busy_d       = busy_q;
        start        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_Load) begin
                    start   = 1'b1;
                    value_d = bus.i_Value;
                end else if (pend_valid_q) begin
                    start        = 1'b1;
                    value_d      = pend_value_q;
                    pend_valid_d = 1'b0;
                end else if (REFRESH_EN && refresh_q == REFRESH_LAST) begin
                    start = 1'b1;
                end else if (REFRESH_EN) begin
                    refresh_d = refresh_q + 1'b1;
                end
                if (start) begin
                    state_d   = DRV_LO;
                    busy_d    = 1'b1;
                    refresh_d = '0;
                end
            end
            DRV_LO: begin
                enc_num_d = value_q[3:0];
                wait_d    = '0;
                state_d   = WAIT_LO;
            end
            WAIT_LO: begin
                if (wait_q == LAT_LO) begin
                    seg2_d    = ~bus.i_Enc_Seg;
                    enc_num_d = value_q[7:4];
                    wait_d    = '0;
                    state_d   = WAIT_HI;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DRV_HI: begin
                enc_num_d = value_q[7:4];
                wait_d    = '0;
                state_d   = WAIT_HI;
            end
            WAIT_HI: begin
                if (wait_q == LAT_HI) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
                    seg1_d = (value_q[7:4] == 4'h0) ? SEG_BLANK : ~bus.i_Enc_Seg;
`else
                    seg1_d = ~bus.i_Enc_Seg;
`endif
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Loads arriving mid-sequence are parked; the newest one overwrites any older one.
        if (state_q != IDLE && bus.i_Load) begin
            pend_value_d = bus.i_Value;
            pend_valid_d = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= IDLE;
            value_q      <= '0;
            pend_value_q <= '0;
            pend_valid_q <= 1'b0;
            enc_num_q    <= '0;
            wait_q       <= '0;
            refresh_q    <= '0;
            seg1_q       <= SEG_BLANK;
            seg2_q       <= SEG_BLANK;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            pend_value_q <= pend_value_d;
            pend_valid_q <= pend_valid_d;
            enc_num_q    <= enc_num_d;
            wait_q       <= wait_d;
            refresh_q    <= refresh_d;
            seg1_q       <= seg1_d;
            seg2_q       <= seg2_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.o_Busy     = busy_q;
    assign bus.o_Enc_Num  = enc_num_q;
    assign bus.o_Segment1 = seg1_q;
    assign bus.o_Segment2 = seg2_q;

endmodule

// File: tb/tb_seg_digit_scheduler.sv
// Scoreboard bench: two schedulers (latency 1 with refresh 16, latency 3 without refresh).
// Honors SEG_LEADING_ZERO_BLANK_EN when computing the expected tens digit.
module tb_seg_digit_scheduler;

    typedef struct packed {
        logic [6:0] s1;
        logic [6:0] s2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    seg_digit_scheduler_if bus1 ();
    seg_digit_scheduler_if bus3 ();

    seg_digit_scheduler #(.ENC_LATENCY(1), .REFRESH_CYCLES(16)) dut1 (
        .i_Clk(clk), .i_Reset(rst), .bus(bus1)
    );
    seg_digit_scheduler #(.ENC_LATENCY(3), .REFRESH_CYCLES(0)) dut3 (
        .i_Clk(clk), .i_Reset(rst), .bus(bus3)
    );

    function automatic logic [6:0] enc7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] exp_s1(input logic [7:0] v);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        return (v[7:4] == 4'h0) ? 7'h7F : ~enc7(v[7:4]);
`else
        return ~enc7(v[7:4]);
`endif
    endfunction

    // Encoder models: result usable at the edge ENC_LATENCY cycles after the nibble is driven.
    logic [3:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= bus3.o_Enc_Num;
        p2 <= p1;
    end
    assign bus1.i_Enc_Seg = enc7(bus1.o_Enc_Num);
    assign bus3.i_Enc_Seg = enc7(p2);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h want=%0h", name, k, act, exp);
        end
    endtask

    // Transaction-level reference: each sequence occupies 2*L+2 edges after its start edge.
    int         lat[2]  = '{1, 3};
    int         rcyc[2] = '{16, 0};
    int         busy_left[2];
    bit         pend_v[2];
    logic [7:0] pend_val[2];
    logic [7:0] held[2];
    int         rcnt[2];
    int         starts[2];
    exp_t       q0[$];
    exp_t       q1[$];

    task automatic model_start(input int d, input logic [7:0] v);
        exp_t e;
        held[d]      = v;
        busy_left[d] = 2 * lat[d] + 2;
        rcnt[d]      = 0;
        starts[d]++;
        e.s1 = exp_s1(v);
        e.s2 = ~enc7(v[3:0]);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_step(input int d, input bit ld, input logic [7:0] v);
        if (busy_left[d] == 0) begin
            if (ld) model_start(d, v);
            else if (pend_v[d]) begin
                pend_v[d] = 1'b0;
                model_start(d, pend_val[d]);
            end else if (rcyc[d] != 0) begin
                if (rcnt[d] == rcyc[d] - 1) model_start(d, held[d]);
                else rcnt[d]++;
            end
        end else begin
            if (ld) begin
                pend_v[d]   = 1'b1;
                pend_val[d] = v;
            end
            busy_left[d]--;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                busy_left[d] = 0; pend_v[d] = 1'b0; pend_val[d] = '0;
                held[d] = '0; rcnt[d] = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            model_step(0, bus1.i_Load, bus1.i_Value);
            model_step(1, bus3.i_Load, bus3.i_Value);
        end
    end

    // Monitors: a falling o_Busy marks a completed sequence whose captures are compared.
    bit prev_busy[2];
    int rises[2];

    task automatic monitor(input int d, input logic busy, input logic [6:0] s1, input logic [6:0] s2);
        exp_t e;
        if (rst) begin
            prev_busy[d] = 1'b0;
            return;
        end
        if (!prev_busy[d] && busy) rises[d]++;
        if (prev_busy[d] && !busy) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected dut=%0d got=%0h/%0h want=none", d, s1, s2);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("sb_seg1_d%0d", d), rises[d], {25'd0, s1}, {25'd0, e.s1});
                check($sformatf("sb_seg2_d%0d", d), rises[d], {25'd0, s2}, {25'd0, e.s2});
            end
        end
        prev_busy[d] = busy;
    endtask

    always @(negedge clk) monitor(0, bus1.o_Busy, bus1.o_Segment1, bus1.o_Segment2);
    always @(negedge clk) monitor(1, bus3.o_Busy, bus3.o_Segment1, bus3.o_Segment2);

    task automatic step(input bit ld, input logic [7:0] v);
        @(negedge clk);
        bus1.i_Load = ld; bus1.i_Value = v;
        bus3.i_Load = ld; bus3.i_Value = v;
        @(posedge clk);
        #1;
    endtask

    task automatic tchk(input string tag, input int k, input int L, input logic [7:0] v,
                        input logic [6:0] o1, input logic [6:0] o2, input logic [3:0] oe,
                        input logic busy, input logic [3:0] en,
                        input logic [6:0] s1, input logic [6:0] s2);
        logic [3:0] ee;
        ee = (k == 0) ? oe : (k <= L + 1) ? v[3:0] : v[7:4];
        check({tag, "_busy"}, k, {31'd0, busy}, {31'd0, (k < 2 * L + 2)});
        check({tag, "_enc"},  k, {28'd0, en}, {28'd0, ee});
        check({tag, "_seg2"}, k, {25'd0, s2}, {25'd0, (k >= L + 2) ? ~enc7(v[3:0]) : o2});
        check({tag, "_seg1"}, k, {25'd0, s1}, {25'd0, (k >= 2 * L + 2) ? exp_s1(v) : o1});
    endtask

    // Cycle-exact capture timing for both latencies; starts from known prior outputs.
    task automatic timing(input logic [7:0] v, input logic [6:0] o1, input logic [6:0] o2,
                          input logic [3:0] oe);
        for (int k = 0; k <= 9; k++) begin
            step(k == 0, v);
            tchk("t_l1", k, 1, v, o1, o2, oe, bus1.o_Busy, bus1.o_Enc_Num, bus1.o_Segment1, bus1.o_Segment2);
            tchk("t_l3", k, 3, v, o1, o2, oe, bus3.o_Busy, bus3.o_Enc_Num, bus3.o_Segment1, bus3.o_Segment2);
        end
    endtask

    initial begin
        int r0, m0;
        bus1.i_Load = 1'b0; bus1.i_Value = '0;
        bus3.i_Load = 1'b0; bus3.i_Value = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg1", 0, {25'd0, bus1.o_Segment1}, 32'h7F);
        check("rst_seg2", 0, {25'd0, bus1.o_Segment2}, 32'h7F);
        check("rst_busy", 0, {31'd0, bus1.o_Busy}, 32'h0);
        check("rst_enc",  0, {28'd0, bus1.o_Enc_Num}, 32'h0);
        check("rst_busy3", 0, {31'd0, bus3.o_Busy}, 32'h0);
        check("rst_seg1_3", 0, {25'd0, bus3.o_Segment1}, 32'h7F);
        @(negedge clk);
        rst = 1'b0;

        timing(8'h3A, 7'h7F, 7'h7F, 4'h0);
        timing(8'h9C, exp_s1(8'h3A), ~enc7(4'hA), 4'h3);

        // Back-to-back loads: only the first and the last are displayed.
        step(1'b1, 8'h12);
        step(1'b1, 8'h45);
        step(1'b1, 8'h78);
        repeat (30) step(1'b0, 8'h00);

        step(1'b1, 8'h07);
        repeat (12) step(1'b0, 8'h00);

        // Refresh window: held value re-encoded twice with no new loads.
        @(negedge clk); #1;
        r0 = rises[0]; m0 = starts[0];
        step(1'b1, 8'hF0);
        repeat (40) step(1'b0, 8'h00);
        @(negedge clk); #1;
        check("refresh_starts", rises[0] - r0, rises[0] - r0, starts[0] - m0);

        // Reset while the low nibble is in flight.
        step(1'b1, 8'h55);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b1;
        #1;
        check("mid_rst_seg1", 0, {25'd0, bus1.o_Segment1}, 32'h7F);
        check("mid_rst_seg2", 0, {25'd0, bus1.o_Segment2}, 32'h7F);
        check("mid_rst_busy", 0, {31'd0, bus1.o_Busy}, 32'h0);
        check("mid_rst_enc",  0, {28'd0, bus1.o_Enc_Num}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h21);
        repeat (12) step(1'b0, 8'h00);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 5) == 0, 8'($urandom));
        repeat (30) step(1'b0, 8'h00);
        @(negedge clk); #1;

        check("drain_q0", 0, q0.size(), 0);
        check("drain_q1", 0, q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
